// File: rtl/ms_uart_pkg.sv
// Shared defaults and entry layout for the UART receive buffer.
package ms_uart_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;
    localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);

    // A stored entry is {err, data}; the parity flag sits just above the byte.
    localparam int ERR_IDX_DEF = DATA_W_DEF;

    function automatic int err_idx(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/ms_uart_sync_edge.sv
// Two-stage sampler for a bus plus strobe, with a rising-edge pulse on the strobe.
module ms_uart_sync_edge #(
    parameter int W       = 8,
    parameter bit STB_RST = 1'b1
) (
    input  logic         clk,
    input  logic         srst,
    input  logic [W-1:0] bus,
    input  logic         stb,
    output logic [W-1:0] bus_s,
    output logic         rise
);

    logic [W-1:0] bus_s1_reg;
    logic [W-1:0] bus_s2_reg;
    logic         stb_s1_reg;
    logic         stb_s2_reg;
    logic         stb_s3_reg;

    // Strobe stages reset to STB_RST so a level already high at release is not an edge.
    always_ff @(posedge clk) begin
        if (srst) begin
            bus_s1_reg <= '0;
            bus_s2_reg <= '0;
            stb_s1_reg <= STB_RST;
            stb_s2_reg <= STB_RST;
            stb_s3_reg <= STB_RST;
        end else begin
            bus_s1_reg <= bus;
            bus_s2_reg <= bus_s1_reg;
            stb_s1_reg <= stb;
            stb_s2_reg <= stb_s1_reg;
            stb_s3_reg <= stb_s2_reg;
        end
    end

    assign bus_s = bus_s2_reg;
    assign rise  = stb_s2_reg & ~stb_s3_reg;

endmodule

// File: rtl/ms_uart_rx_fifo.sv
// Show-ahead receive FIFO fed by the UART receiver, with sticky overflow on drop.
module ms_uart_rx_fifo
    import ms_uart_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic [DATA_W-1:0] RX_DATA,
    input  logic              RX_DONE,
    input  logic              RX_ERR,
    input  logic              RD_READY,
    input  logic              CLR_OVF,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              RD_ERR,
    output logic              RD_VALID,
    output logic              FULL,
    output logic [ADDR_W:0]   COUNT,
    output logic              OVERFLOW
);

    localparam int ERR_BIT = err_idx(DATA_W);

    logic [DATA_W:0]   entry_s2;
    logic              push_req;
    logic [DATA_W:0]   mem [DEPTH];
    logic [DATA_W:0]   head;
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   count_next;
    logic              overflow_reg;
    logic              pop;
    logic              push_ok;
    logic              ovf_evt;

    ms_uart_sync_edge #(
        .W       (DATA_W + 1),
        .STB_RST (1'b1)
    ) u_sync (
        .clk   (CLK),
        .srst  (RESETN),
        .bus   ({RX_ERR, RX_DATA}),
        .stb   (RX_DONE),
        .bus_s (entry_s2),
        .rise  (push_req)
    );

    assign RD_VALID = (count_reg != '0);
    assign FULL     = (count_reg == (ADDR_W + 1)'(DEPTH));
    assign pop      = RD_VALID & RD_READY;
    // At full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points.
    assign push_ok  = push_req & (~FULL | pop);
    assign ovf_evt  = push_req & FULL & ~pop;

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= entry_s2;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESETN) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
            if (ovf_evt) begin
                overflow_reg <= 1'b1;
            end else if (CLR_OVF) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign head     = RD_VALID ? mem[rd_ptr_reg] : '0;
    assign RD_DATA  = head[DATA_W-1:0];
    assign RD_ERR   = head[ERR_BIT];
    assign COUNT    = count_reg;
    assign OVERFLOW = overflow_reg;

endmodule

// File: tb/tb_ms_uart_rx_fifo.sv
// Directed self-checking bench for ms_uart_rx_fifo.
module tb_ms_uart_rx_fifo;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b1;
    logic [7:0] RX_DATA = '0;
    logic       RX_DONE = 1'b0;
    logic       RX_ERR = 1'b0;
    logic       RD_READY = 1'b0;
    logic       CLR_OVF = 1'b0;
    logic [7:0] RD_DATA;
    logic       RD_ERR;
    logic       RD_VALID;
    logic       FULL;
    logic [3:0] COUNT;
    logic       OVERFLOW;

    int checks = 0;
    int errors = 0;

    ms_uart_rx_fifo dut (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .RX_DATA  (RX_DATA),
        .RX_DONE  (RX_DONE),
        .RX_ERR   (RX_ERR),
        .RD_READY (RD_READY),
        .CLR_OVF  (CLR_OVF),
        .RD_DATA  (RD_DATA),
        .RD_ERR   (RD_ERR),
        .RD_VALID (RD_VALID),
        .FULL     (FULL),
        .COUNT    (COUNT),
        .OVERFLOW (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Entry is written on the third edge after RX_DONE rises; low phase lets s3 see 0 again.
    task automatic frame(input logic [7:0] d, input logic e);
        RX_DATA = d;
        RX_ERR  = e;
        RX_DONE = 1'b1;
        repeat (3) tick();
        RX_DONE = 1'b0;
        RX_DATA = '0;
        RX_ERR  = 1'b0;
        repeat (3) tick();
    endtask

    task automatic pop_one();
        RD_READY = 1'b1;
        tick();
        RD_READY = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_count", COUNT, 0);
        check("rst_valid", RD_VALID, 0);
        check("rst_full", FULL, 0);
        check("rst_ovf", OVERFLOW, 0);
        check("rst_data", {RD_ERR, RD_DATA}, 0);
        RESETN = 1'b0;
        repeat (2) tick();

        // Single long frame: latency and single push
        RX_DATA = 8'hA5;
        RX_ERR  = 1'b0;
        RX_DONE = 1'b1;
        tick();
        check("lat_k", RD_VALID, 0);
        tick();
        check("lat_k1", RD_VALID, 0);
        tick();
        check("lat_k2_valid", RD_VALID, 1);
        check("lat_k2_data", RD_DATA, 8'hA5);
        check("lat_k2_err", RD_ERR, 0);
        check("lat_k2_count", COUNT, 1);
        repeat (17) tick();
        RX_DONE = 1'b0;
        repeat (3) tick();
        check("long_count", COUNT, 1);
        pop_one();
        check("single_empty", RD_VALID, 0);

        // Parity flag carried per entry
        frame(8'h3C, 1'b1);
        frame(8'h0F, 1'b0);
        check("par_count", COUNT, 2);
        check("par_head0", {RD_ERR, RD_DATA}, 9'h13C);
        pop_one();
        check("par_head1", {RD_ERR, RD_DATA}, 9'h00F);
        pop_one();
        check("par_empty_data", RD_DATA, 0);
        check("par_empty_valid", RD_VALID, 0);

        // Fill and overflow
        for (int i = 1; i <= 9; i++) frame(8'(i), 1'b0);
        check("fill_full", FULL, 1);
        check("fill_count", COUNT, 8);
        check("fill_ovf", OVERFLOW, 1);
        CLR_OVF = 1'b1;
        tick();
        CLR_OVF = 1'b0;
        check("clr_ovf", OVERFLOW, 0);
        // Overflow event on the same edge as CLR_OVF: set wins
        RX_DATA = 8'hEE;
        RX_DONE = 1'b1;
        repeat (2) tick();
        CLR_OVF = 1'b1;
        tick();
        CLR_OVF = 1'b0;
        check("clr_vs_set", OVERFLOW, 1);
        check("clr_vs_set_cnt", COUNT, 8);
        RX_DONE = 1'b0;
        repeat (3) tick();
        CLR_OVF = 1'b1;
        tick();
        CLR_OVF = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("fill_pop%0d", i), RD_DATA, i);
            pop_one();
        end
        check("fill_drained", COUNT, 0);
        check("fill_ovf_cleared", OVERFLOW, 0);

        // Push and pop together at full
        for (int i = 0; i < 8; i++) frame(8'h11 + 8'(i), 1'b0);
        check("pp_full_pre", FULL, 1);
        RX_DATA = 8'h19;
        RX_DONE = 1'b1;
        repeat (2) tick();
        RD_READY = 1'b1;
        tick();
        RD_READY = 1'b0;
        check("pp_full_count", COUNT, 8);
        check("pp_full_ovf", OVERFLOW, 0);
        RX_DONE = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pp_full_pop%0d", i), RD_DATA, 8'h12 + 8'(i));
            pop_one();
        end
        check("pp_full_drained", COUNT, 0);

        // Push and pop together at empty: pop ignored
        RX_DATA = 8'h77;
        RX_DONE = 1'b1;
        repeat (2) tick();
        RD_READY = 1'b1;
        tick();
        RD_READY = 1'b0;
        check("pp_empty_count", COUNT, 1);
        check("pp_empty_data", RD_DATA, 8'h77);
        RX_DONE = 1'b0;
        repeat (3) tick();
        pop_one();

        // Wrap-around across pointer boundary
        for (int i = 0; i < 20; i++) begin
            frame(8'h40 + 8'(i), i[0]);
            check($sformatf("wrap_data%0d", i), {RD_ERR, RD_DATA}, {i[0], 8'h40 + 8'(i)});
            check($sformatf("wrap_full%0d", i), FULL, 0);
            pop_one();
        end
        check("wrap_empty", COUNT, 0);

        // Reset with entries stored and RX_DONE held high through release
        for (int i = 0; i < 5; i++) frame(8'hA0 + 8'(i), 1'b0);
        check("rst5_pre", COUNT, 5);
        RX_DATA = 8'h55;
        RX_DONE = 1'b1;
        RESETN  = 1'b1;
        tick();
        check("rst5_count", COUNT, 0);
        check("rst5_valid", RD_VALID, 0);
        check("rst5_data", RD_DATA, 0);
        tick();
        RESETN = 1'b0;
        repeat (5) tick();
        check("rst5_nopush", COUNT, 0);
        RX_DONE = 1'b0;
        repeat (3) tick();
        frame(8'h5A, 1'b1);
        check("rst5_repush_cnt", COUNT, 1);
        check("rst5_repush_data", {RD_ERR, RD_DATA}, 9'h15A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
